// File: rtl/int_calc_pkg.sv
// int_calc_pkg: shared state encoding and default width for the integer calculators
package int_calc_pkg;
  localparam int W_DEF = 8;
  typedef enum logic [1:0] {IDLE, ACCUM, FINISH} calc_state_t;
endpackage

// File: rtl/int_square_calculator_if.sv
// int_square_calculator_if: start/operand request and registered result bundle
interface int_square_calculator_if import int_calc_pkg::*; #(parameter int W = W_DEF);
  logic S;
  logic [W-1:0] X;
  logic [2*W-1:0] sq;
  logic Busy;
  logic Done;
  modport master (output S, X, input sq, Busy, Done);
  modport slave (input S, X, output sq, Busy, Done);
endinterface

// File: rtl/int_square_calculator.sv
// int_square_calculator: multiplier-free X*X by summing the first X odd integers
module int_square_calculator import int_calc_pkg::*; #(parameter int W = W_DEF) (
  input logic Clock,
  input logic Reset,
  int_square_calculator_if.slave bus
);
  calc_state_t state;
  logic [2*W-1:0] acc;
  logic [W:0] d;
  logic [W-1:0] cnt;
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      bus.sq <= '0;
      bus.Done <= 1'b0;
      bus.Busy <= 1'b0;
      acc <= '0;
      d <= (W+1)'(1);
      cnt <= '0;
    end else begin
      bus.Done <= 1'b0;
      case (state)
        IDLE: if (bus.S) begin
          cnt <= bus.X;
          acc <= '0;
          d <= (W+1)'(1);
          bus.Busy <= 1'b1;
          state <= (bus.X != '0) ? ACCUM : FINISH;
        end
        ACCUM: begin
          acc <= acc + (2*W)'(d);
          d <= d + (W+1)'(2);
          cnt <= cnt - W'(1);
          state <= (cnt == W'(1)) ? FINISH : ACCUM;
        end
        FINISH: begin
          bus.sq <= acc;
          bus.Done <= 1'b1;
          bus.Busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_int_square_calculator.sv
// tb_int_square_calculator: directed checks of latency, results, busy window, reset abort and back-to-back starts
module tb_int_square_calculator;
  logic Clock = 1'b0;
  logic Reset = 1'b1;
  int passes = 0;
  int total = 0;
  int n;
  int busy_n;
  int done_n;
  int_square_calculator_if #(.W(8)) bus();
  int_square_calculator #(.W(8)) dut (.Clock(Clock), .Reset(Reset), .bus(bus));
  always #5 Clock = ~Clock;
  task automatic step();
    @(posedge Clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask
  task automatic wait_done(output int edges, output int busy_cycles);
    edges = 0;
    busy_cycles = 1;
    while (!bus.Done && edges < 400) begin
      step();
      edges++;
      if (bus.Busy) busy_cycles++;
    end
  endtask
  task automatic run(input string tag, input logic [7:0] x, input logic [15:0] exp_sq);
    int e;
    int b;
    bus.S = 1'b1;
    bus.X = x;
    step();
    chk({tag, "_busy_on"}, 64'(bus.Busy), 64'd1);
    bus.S = 1'b0;
    bus.X = ~x;
    wait_done(e, b);
    chk({tag, "_latency"}, 64'(e), 64'(x) + 64'd1);
    chk({tag, "_sq"}, 64'(bus.sq), 64'(exp_sq));
    chk({tag, "_busy_cycles"}, 64'(b), 64'(x) + 64'd1);
    step();
    chk({tag, "_done_pulse"}, 64'(bus.Done), 64'd0);
    chk({tag, "_sq_hold"}, 64'(bus.sq), 64'(exp_sq));
  endtask
  initial begin
    bus.S = 1'b0;
    bus.X = '0;
    step();
    step();
    Reset = 1'b0;
    chk("rst_sq", 64'(bus.sq), 64'd0);
    chk("rst_done", 64'(bus.Done), 64'd0);
    chk("rst_busy", 64'(bus.Busy), 64'd0);
    run("x0", 8'd0, 16'd0);
    run("x1", 8'd1, 16'd1);
    run("x12", 8'd12, 16'd144);
    run("x255", 8'd255, 16'd65025);
    bus.S = 1'b1;
    bus.X = 8'd5;
    step();
    bus.X = 8'd9;
    done_n = 0;
    n = 0;
    while (!bus.Done && n < 400) begin
      step();
      n++;
    end
    bus.S = 1'b0;
    chk("ign_latency", 64'(n), 64'd6);
    chk("ign_sq", 64'(bus.sq), 64'd25);
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.Done) done_n++;
    end
    chk("ign_extra_done", 64'(done_n), 64'd0);
    chk("ign_idle", 64'(bus.Busy), 64'd0);
    chk("ign_sq_hold", 64'(bus.sq), 64'd25);
    bus.S = 1'b1;
    bus.X = 8'd7;
    step();
    bus.S = 1'b0;
    step();
    step();
    Reset = 1'b1;
    bus.S = 1'b1;
    step();
    Reset = 1'b0;
    bus.S = 1'b0;
    chk("abort_busy", 64'(bus.Busy), 64'd0);
    chk("abort_sq", 64'(bus.sq), 64'd0);
    chk("abort_done", 64'(bus.Done), 64'd0);
    done_n = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.Done) done_n++;
    end
    chk("abort_no_done", 64'(done_n), 64'd0);
    run("after_rst_x3", 8'd3, 16'd9);
    bus.S = 1'b1;
    bus.X = 8'd4;
    step();
    bus.S = 1'b0;
    wait_done(n, busy_n);
    chk("b2b_lat4", 64'(n), 64'd5);
    chk("b2b_sq16", 64'(bus.sq), 64'd16);
    bus.S = 1'b1;
    bus.X = 8'd6;
    step();
    bus.S = 1'b0;
    chk("b2b_busy_again", 64'(bus.Busy), 64'd1);
    chk("b2b_done_drop", 64'(bus.Done), 64'd0);
    chk("b2b_sq_hold", 64'(bus.sq), 64'd16);
    wait_done(n, busy_n);
    chk("b2b_lat6", 64'(n), 64'd7);
    chk("b2b_sq36", 64'(bus.sq), 64'd36);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
